demux_frame_serializer: RTL and testbench
=========================================

Name: demux_frame_serializer

Overview:
- Upstream feeder for the team's 1:4 demultiplexer (inputs: 1-bit in, 2-bit sel).
- Accepts parallel data frames tagged with a 2-bit destination channel over a valid/ready handshake.
- Holds the demux select at the destination for the whole frame and shifts the frame out one bit per clock on the demux data input.
- Adds a bit-valid strobe, a configurable inter-frame gap and a frame-done pulse, so downstream consumers know when channel outputs are meaningful.

Parameters:
- DATA_W, 8: frame width in bits; legal range 2..32.
- GAP_CYCLES, 1: idle cycles inserted after each frame before the next accept; legal range 0..15.
- MSB_FIRST, 0: 0 = shift LSB first, 1 = shift MSB first.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- s_valid  input  1  upstream frame valid.
- s_ready  output  1  block can accept a frame.
- s_data  input  DATA_W  frame payload.
- s_dest  input  2  destination channel 0..3.
- demux_in  output  1  serial bit to the demux in port.
- demux_sel  output  2  select to the demux sel port.
- demux_en  output  1  high when demux_in carries a valid frame bit.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: s_ready=0 during rst, 1 on the first cycle after rst deasserts; demux_in=0, demux_sel=2'b00, demux_en=0, frame_done=0, busy=0. State = IDLE, bit counter = 0, shift register = 0.
- States: IDLE, SHIFT, GAP. Encoding comes from the package.
- IDLE:
  - s_ready=1, demux_in=0, demux_en=0.
  - demux_sel holds its last value (0 after reset).
  - Accept occurs when s_valid && s_ready at a clock edge: latch s_data into the shift register and s_dest into demux_sel, then go to SHIFT.
- Latency: bit 0 (LSB, or MSB if MSB_FIRST=1) appears on demux_in with demux_en=1 in the first cycle after the accept edge.
- SHIFT:
  - s_ready=0, demux_en=1.
  - One bit is presented per cycle for exactly DATA_W cycles; demux_sel is stable throughout.
  - The bit counter runs 0..DATA_W-1.
  - When the counter reaches DATA_W-1: frame_done=1 for that cycle. The next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP:
  - demux_in=0, demux_en=0, s_ready=0, demux_sel held.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
- Minimum frame spacing: accept-to-accept is DATA_W+GAP_CYCLES+1 cycles, because IDLE lasts at least one cycle.
- Upstream obligation: s_data and s_dest are sampled only on the accept edge. Changes while s_ready=0 are ignored.
- s_valid held high continuously: frames are accepted back-to-back at the minimum spacing with no loss or duplication.
- s_dest takes any value 0..3 with no reserved codes. demux_sel changes only on the accept edge, never mid-frame.
- rst asserted mid-frame (SHIFT or GAP): at the next edge all outputs return to reset values. The partial frame is discarded with no frame_done pulse and is not resumed.
- rst and s_valid high in the same cycle: rst wins and no accept occurs.
- Bit counter width is $clog2(DATA_W). Gap counter is 4 bits. No counter may wrap past its terminal value.

Decomposition:
- Shared package holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2);
  - NUM_CH=4 and DEST_W=2, so the demux and this block agree on select width.
- No sub-module. The block is one FSM with a shift register and two counters. The existing 1:4 demux is instantiated alongside it only in the system bench, not inside this block.

Test Plan:
- Reset then idle: hold rst 2 cycles -> s_ready=0 during rst, 1 on the first cycle after; demux_en=0, demux_sel=0, busy=0.
- Single LSB-first frame, DATA_W=8: s_data=8'hA5, s_dest=2 -> next 8 cycles demux_in=1,0,1,0,0,1,0,1, demux_sel=2, demux_en=1; frame_done on the 8th bit; then 1 gap cycle; s_ready=1 after.
- MSB_FIRST=1, s_data=8'h81, s_dest=3 -> demux_in=1,0,0,0,0,0,0,1 with demux_sel=3 held.
- Back-to-back frames, s_valid held high: dest 0 then dest 1 -> accepts exactly 10 cycles apart; sel changes only on the accept edge; system bench with the 1:4 demux shows bits on out[0] then out[1] only.
- GAP_CYCLES=0: second accept exactly 9 cycles after the first; no cycle with demux_en=1 and a changing sel.
- Reset mid-frame: assert rst after bit 3 of 8'hFF -> next cycle demux_en=0, demux_in=0, no frame_done; a following new frame is serialized completely.

Source files
------------

// File: rtl/demux_frame_serializer_pkg.sv
// Shared definitions for the demux frame serializer and the 1:4 demux it feeds.
// The demux and this block both take the select width from here, so they cannot disagree.
package demux_frame_serializer_pkg;

    localparam int NUM_CH = 4;
    localparam int DEST_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/demux_frame_serializer_if.sv
// Upstream frame handshake plus the serial/select/strobe lines toward the demux.
// Master is the frame source; slave is the serializer.
interface demux_frame_serializer_if #(
    parameter int DATA_W = 8
);
    import demux_frame_serializer_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [DEST_W-1:0] s_dest;
    logic              demux_in;
    logic [DEST_W-1:0] demux_sel;
    logic              demux_en;
    logic              frame_done;
    logic              busy;

    modport master (
        output s_valid, s_data, s_dest,
        input  s_ready, demux_in, demux_sel, demux_en, frame_done, busy
    );

    modport slave (
        input  s_valid, s_data, s_dest,
        output s_ready, demux_in, demux_sel, demux_en, frame_done, busy
    );

endinterface

// File: rtl/demux_frame_serializer.sv
// Serializes tagged parallel frames onto the 1:4 demux: select held per frame, one bit per clock,
// bit-valid strobe, frame-done pulse on the last bit and a fixed idle gap between frames.
module demux_frame_serializer
    import demux_frame_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_frame_serializer_if.slave bus
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_gap_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_s_ready;
    logic                r_demux_in;
    logic [DEST_W-1:0]   r_demux_sel;
    logic                r_demux_en;
    logic                r_frame_done;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [3:0]          w_gap_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_in_nxt;
    logic [DEST_W-1:0]   w_sel_nxt;
    logic                w_en_nxt;
    logic                w_done_nxt;
    logic                w_accept;

    function automatic logic first_bit(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? d[DATA_W-1] : d[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? (d << 1) : (d >> 1);
    endfunction

    assign w_accept  = (r_state == IDLE) && r_s_ready && bus.s_valid;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Every output is computed one cycle ahead here and registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_shift_nxt = r_shift;
        w_in_nxt    = 1'b0;
        w_sel_nxt   = r_demux_sel;
        w_en_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = shift_once(bus.s_data);
                    w_in_nxt    = first_bit(bus.s_data);
                    w_sel_nxt   = bus.s_dest;
                    w_en_nxt    = 1'b1;
                    w_done_nxt  = (LAST_BIT == '0);
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_cnt_nxt = '0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_shift_nxt = shift_once(r_shift);
                    w_in_nxt    = first_bit(r_shift);
                    w_en_nxt    = 1'b1;
                    w_done_nxt  = (w_cnt_inc == LAST_BIT);
                end
            end
            GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
            r_s_ready    <= 1'b0;
            r_demux_in   <= 1'b0;
            r_demux_sel  <= '0;
            r_demux_en   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_shift      <= w_shift_nxt;
            r_s_ready    <= (w_state_nxt == IDLE);
            r_demux_in   <= w_in_nxt;
            r_demux_sel  <= w_sel_nxt;
            r_demux_en   <= w_en_nxt;
            r_frame_done <= w_done_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.demux_in   = r_demux_in;
    assign bus.demux_sel  = r_demux_sel;
    assign bus.demux_en   = r_demux_en;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_demux_frame_serializer.sv
// Directed bench for the frame serializer: three builds (LSB-first gap 1, MSB-first, gap 0)
// on one clock; a selector routes the shared stimulus to one build at a time.
module tb_demux_frame_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic [1:0] tb_dest = 2'd0;
    logic [1:0] dut_sel = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic       obs_ready, obs_in, obs_en, obs_done, obs_busy;
    logic [1:0] obs_sel;

    always #5 clk = ~clk;

    demux_frame_serializer_if #(.DATA_W(8)) if_a ();
    demux_frame_serializer_if #(.DATA_W(8)) if_b ();
    demux_frame_serializer_if #(.DATA_W(8)) if_c ();

    assign if_a.s_valid = tb_valid && (dut_sel == 2'd0);
    assign if_b.s_valid = tb_valid && (dut_sel == 2'd1);
    assign if_c.s_valid = tb_valid && (dut_sel == 2'd2);
    assign if_a.s_data  = tb_data;
    assign if_b.s_data  = tb_data;
    assign if_c.s_data  = tb_data;
    assign if_a.s_dest  = tb_dest;
    assign if_b.s_dest  = tb_dest;
    assign if_c.s_dest  = tb_dest;

    demux_frame_serializer #(.DATA_W(8), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave));
    demux_frame_serializer #(.DATA_W(8), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave));
    demux_frame_serializer #(.DATA_W(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c.slave));

    always_comb begin
        obs_ready = if_a.s_ready;
        obs_in    = if_a.demux_in;
        obs_en    = if_a.demux_en;
        obs_done  = if_a.frame_done;
        obs_busy  = if_a.busy;
        obs_sel   = if_a.demux_sel;
        case (dut_sel)
            2'd1: begin
                obs_ready = if_b.s_ready;
                obs_in    = if_b.demux_in;
                obs_en    = if_b.demux_en;
                obs_done  = if_b.frame_done;
                obs_busy  = if_b.busy;
                obs_sel   = if_b.demux_sel;
            end
            2'd2: begin
                obs_ready = if_c.s_ready;
                obs_in    = if_c.demux_in;
                obs_en    = if_c.demux_en;
                obs_done  = if_c.frame_done;
                obs_busy  = if_c.busy;
                obs_sel   = if_c.demux_sel;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_seq[i] is the hand-derived bit expected on demux_in in the i-th bit cycle.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic [1:0] dest,
                             input logic [7:0] exp_seq, input int gap);
        tb_data  = data;
        tb_dest  = dest;
        tb_valid = 1'b1;
        chk({tag, "_ready_pre"}, obs_ready, 1);
        tick();
        tb_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), obs_in, exp_seq[i]);
            chk($sformatf("%s_en%0d", tag, i), obs_en, 1);
            chk($sformatf("%s_sel%0d", tag, i), obs_sel, dest);
            chk($sformatf("%s_done%0d", tag, i), obs_done, (i == 7) ? 1 : 0);
            chk($sformatf("%s_rdy%0d", tag, i), obs_ready, 0);
            chk($sformatf("%s_busy%0d", tag, i), obs_busy, 1);
            tick();
        end
        for (int g = 0; g < gap; g++) begin
            chk($sformatf("%s_gap_en%0d", tag, g), obs_en, 0);
            chk($sformatf("%s_gap_in%0d", tag, g), obs_in, 0);
            chk($sformatf("%s_gap_rdy%0d", tag, g), obs_ready, 0);
            chk($sformatf("%s_gap_busy%0d", tag, g), obs_busy, 1);
            chk($sformatf("%s_gap_sel%0d", tag, g), obs_sel, dest);
            tick();
        end
        chk({tag, "_ready_post"}, obs_ready, 1);
        chk({tag, "_busy_post"}, obs_busy, 0);
        chk({tag, "_sel_post"}, obs_sel, dest);
        chk({tag, "_done_post"}, obs_done, 0);
    endtask

    // Two frames with s_valid held high; a behavioural 1:4 demux collects the bits per channel.
    task automatic run_b2b(input string tag, input int exp_space);
        int         acc_cyc[2];
        int         n_acc = 0;
        bit         pending = 0;
        int         nbits[4];
        logic [7:0] rx[4];
        int         n_done = 0;
        int         sel_glitch = 0;
        logic       prev_en = 1'b0;
        logic [1:0] prev_sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            nbits[k] = 0;
            rx[k]    = 8'h00;
        end
        acc_cyc[0] = -100;
        acc_cyc[1] = -100;
        tb_data  = 8'h3C;
        tb_dest  = 2'd0;
        tb_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (tb_valid && obs_ready) begin
                if (n_acc < 2) acc_cyc[n_acc] = c;
                n_acc++;
                pending = 1;
            end
            if (obs_en) begin
                nbits[obs_sel]++;
                rx[obs_sel] = {obs_in, rx[obs_sel][7:1]};
                if (prev_en && (obs_sel != prev_sel)) sel_glitch++;
            end
            if (obs_done) n_done++;
            prev_en  = obs_en;
            prev_sel = obs_sel;
            tick();
            if (pending) begin
                pending = 0;
                if (n_acc == 1) begin
                    tb_data = 8'hC3;
                    tb_dest = 2'd1;
                end else begin
                    tb_valid = 1'b0;
                end
            end
        end
        tb_valid = 1'b0;
        chk({tag, "_n_accepts"}, n_acc, 2);
        chk({tag, "_spacing"}, acc_cyc[1] - acc_cyc[0], exp_space);
        chk({tag, "_ch0_bits"}, nbits[0], 8);
        chk({tag, "_ch1_bits"}, nbits[1], 8);
        chk({tag, "_ch23_bits"}, nbits[2] + nbits[3], 0);
        chk({tag, "_ch0_word"}, rx[0], 8'h3C);
        chk({tag, "_ch1_word"}, rx[1], 8'hC3);
        chk({tag, "_n_done"}, n_done, 2);
        chk({tag, "_sel_glitch"}, sel_glitch, 0);
        chk({tag, "_ready_end"}, obs_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_a", if_a.s_ready, 0);
        chk("rst_ready_b", if_b.s_ready, 0);
        chk("rst_ready_c", if_c.s_ready, 0);
        chk("rst_en", obs_en, 0);
        chk("rst_in", obs_in, 0);
        chk("rst_sel", obs_sel, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_done", obs_done, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready_a", if_a.s_ready, 1);
        chk("idle_ready_b", if_b.s_ready, 1);
        chk("idle_ready_c", if_c.s_ready, 1);
        chk("idle_busy", obs_busy, 0);

        dut_sel = 2'd0;
        run_frame("lsb_a5", 8'hA5, 2'd2, 8'b1010_0101, 1);

        dut_sel = 2'd1;
        #1;
        run_frame("msb_81", 8'h81, 2'd3, 8'b1000_0001, 1);

        dut_sel = 2'd0;
        #1;
        run_b2b("b2b_gap1", 10);

        dut_sel = 2'd2;
        #1;
        run_b2b("b2b_gap0", 9);

        dut_sel  = 2'd0;
        tb_data  = 8'h77;
        tb_dest  = 2'd3;
        tb_valid = 1'b1;
        rst      = 1'b1;
        tick();
        chk("rstwin_busy", obs_busy, 0);
        chk("rstwin_en", obs_en, 0);
        chk("rstwin_ready", obs_ready, 0);
        chk("rstwin_sel", obs_sel, 0);
        rst      = 1'b0;
        tb_valid = 1'b0;
        tick();
        chk("rstwin_ready_after", obs_ready, 1);
        chk("rstwin_busy_after", obs_busy, 0);

        tb_data  = 8'hFF;
        tb_dest  = 2'd1;
        tb_valid = 1'b1;
        tick();
        tb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_bit%0d", i), obs_in, 1);
            chk($sformatf("midrst_en%0d", i), obs_en, 1);
            if (i == 3) rst = 1'b1;
            tick();
        end
        chk("midrst_en_after", obs_en, 0);
        chk("midrst_in_after", obs_in, 0);
        chk("midrst_done_after", obs_done, 0);
        chk("midrst_busy_after", obs_busy, 0);
        chk("midrst_sel_after", obs_sel, 0);
        rst = 1'b0;
        tick();
        chk("midrst_done_idle", obs_done, 0);
        chk("midrst_ready_idle", obs_ready, 1);
        run_frame("post_rst_5a", 8'h5A, 2'd3, 8'b0101_1010, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
